// File: rtl/edge_pulse_pkg.sv
// Shared types and width helpers for the edge_pulse_gen block.
package edge_pulse_pkg;

    // Global edge mode; the encoding matches the mode input pins.
    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_e;

    // Debounce counter must hold values up to DEBOUNCE_CYCLES-1.
    function automatic int deb_cnt_w(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

    // Pulse counter must hold PULSE_LEN itself (the reload value).
    function automatic int pulse_cnt_w(input int len);
        return (len < 2) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/edge_pulse_chan.sv
// One channel of edge_pulse_gen: synchroniser, debounce filter, mode-qualified
// edge detector and retriggerable pulse stretcher. The sticky event flag is
// built only when EDGE_PULSE_STICKY_EN is defined.
module edge_pulse_chan
    import edge_pulse_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level,
    input  logic [1:0] mode,
`ifdef EDGE_PULSE_STICKY_EN
    input  logic       flag_clr,
    output logic       flag,
`endif
    output logic       pulse,
    output logic       stable
);

    localparam int CNT_W  = deb_cnt_w(DEBOUNCE_CYCLES);
    localparam int PCNT_W = pulse_cnt_w(PULSE_LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PULSE_LEN);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PCNT_W-1:0]      pcnt_q, pcnt_d;
    logic                   stable_q, stable_d;
    logic                   pulse_q, pulse_d;
    logic                   sync_out;
    logic                   flip;
    logic                   evt;
    edge_mode_e             mode_e;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign mode_e   = edge_mode_e'(mode);

    // Shift the raw level into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], level};
    end

    // Debounce, edge qualification and pulse counter next-state.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        flip     = 1'b0;
        evt      = 1'b0;
        pcnt_d   = pcnt_q;

        if (sync_out != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                flip     = 1'b1;
                stable_d = sync_out;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // sync_out is the level stable is about to take on.
        case (mode_e)
            EDGE_RISE: evt = flip & sync_out;
            EDGE_FALL: evt = flip & ~sync_out;
            EDGE_BOTH: evt = flip;
            default:   evt = 1'b0;
        endcase

        if (evt) begin
            pcnt_d = PCNT_LOAD;
        end else if (pcnt_q != '0) begin
            pcnt_d = pcnt_q - 1'b1;
        end

        // Registered from the next count so the pulse rises with stable.
        pulse_d = (pcnt_d != '0);
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            pcnt_q   <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            pcnt_q   <= pcnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse  = pulse_q;
    assign stable = stable_q;

`ifdef EDGE_PULSE_STICKY_EN
    logic flag_q, flag_d;

    // Sticky flag: an event in the same cycle as a clear keeps it set.
    always_comb begin
        flag_d = flag_q;
        if (evt) begin
            flag_d = 1'b1;
        end else if (flag_clr) begin
            flag_d = 1'b0;
        end
    end

    // Sticky flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;
`endif

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel level-to-pulse converter for asynchronous board inputs.
// Each channel is an independent edge_pulse_chan; mode is shared.
// Optional sticky per-channel event flags: define EDGE_PULSE_STICKY_EN.
module edge_pulse_gen
    import edge_pulse_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    input  logic [1:0]       mode,
`ifdef EDGE_PULSE_STICKY_EN
    input  logic [WIDTH-1:0] flag_clr,
    output logic [WIDTH-1:0] flag,
`endif
    output logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] stable
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        edge_pulse_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .PULSE_LEN       (PULSE_LEN)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .level    (level[i]),
            .mode     (mode),
`ifdef EDGE_PULSE_STICKY_EN
            .flag_clr (flag_clr[i]),
            .flag     (flag[i]),
`endif
            .pulse    (pulse[i]),
            .stable   (stable[i])
        );
    end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Self-checking bench for edge_pulse_gen: two instances (default parameters,
// and a long-pulse / short-debounce variant) against a history-based model.
module tb_edge_pulse_gen;

    localparam int W    = 4;
    localparam int NMAX = 4096;

    function automatic int p_sync(input int i);
        return 2;
    endfunction
    function automatic int p_deb(input int i);
        return (i == 0) ? 4 : 2;
    endfunction
    function automatic int p_pl(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] level = '0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] pulse0, stable0, pulse1, stable1;
`ifdef EDGE_PULSE_STICKY_EN
    logic [W-1:0] flag_clr = '0;
    logic [W-1:0] flag0, flag1;
`endif

    edge_pulse_gen #(
        .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PULSE_LEN(1)
    ) dut (
        .clk(clk), .rst(rst), .level(level), .mode(mode),
`ifdef EDGE_PULSE_STICKY_EN
        .flag_clr(flag_clr), .flag(flag0),
`endif
        .pulse(pulse0), .stable(stable0)
    );

    edge_pulse_gen #(
        .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(2), .PULSE_LEN(4)
    ) dut4 (
        .clk(clk), .rst(rst), .level(level), .mode(mode),
`ifdef EDGE_PULSE_STICKY_EN
        .flag_clr(flag_clr), .flag(flag1),
`endif
        .pulse(pulse1), .stable(stable1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check4(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Keeps every sampled level since reset. The synchronised value seen at
    // edge j is the level sampled SYNC edges earlier. stable flips at edge n
    // when the last DEB synchronised samples, all taken after the previous
    // flip, differ from it. A pulse is high at edge n when an accepted event
    // happened within the last PULSE_LEN edges.
    int           n_e       [2];
    int           last_flip [2][W];
    int           last_evt  [2][W];
    bit           m_stab    [2][W];
    bit           m_flag    [2][W];
    bit           lv        [2][W][NMAX];
    logic [W-1:0] exp_stable [2];
    logic [W-1:0] exp_pulse  [2];
    logic [W-1:0] exp_flag   [2];

    function automatic bit sync_at(input int inst, input int ch, input int j);
        int idx;
        idx = j - p_sync(inst);
        if (idx < 0) return 1'b0;
        return lv[inst][ch][idx];
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int n;
        bit all_diff, evt;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                n_e[i] = 0;
                exp_stable[i] = '0;
                exp_pulse[i]  = '0;
                exp_flag[i]   = '0;
                for (int c = 0; c < W; c++) begin
                    last_flip[i][c] = -1;
                    last_evt[i][c]  = -1000;
                    m_stab[i][c]    = 1'b0;
                    m_flag[i][c]    = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                n = n_e[i];
                if (n >= NMAX) begin
                    $display("FAIL model_history actual=%0d required<%0d", n, NMAX);
                    $fatal(1, "model history exhausted");
                end
                for (int c = 0; c < W; c++) begin
                    lv[i][c][n] = level[c];
                    all_diff = (n - p_deb(i) + 1) > last_flip[i][c];
                    for (int j = n - p_deb(i) + 1; j <= n; j++)
                        if (sync_at(i, c, j) == m_stab[i][c]) all_diff = 1'b0;
                    evt = 1'b0;
                    if (all_diff) begin
                        m_stab[i][c]    = ~m_stab[i][c];
                        last_flip[i][c] = n;
                        case (mode)
                            2'b00:   evt = m_stab[i][c];
                            2'b01:   evt = ~m_stab[i][c];
                            2'b10:   evt = 1'b1;
                            default: evt = 1'b0;
                        endcase
                        if (evt) last_evt[i][c] = n;
                    end
`ifdef EDGE_PULSE_STICKY_EN
                    if (evt) m_flag[i][c] = 1'b1;
                    else if (flag_clr[c]) m_flag[i][c] = 1'b0;
`endif
                    exp_stable[i][c] = m_stab[i][c];
                    exp_pulse[i][c]  = (n - last_evt[i][c]) < p_pl(i);
                    exp_flag[i][c]   = m_flag[i][c];
                end
                n_e[i] = n + 1;
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check4("stable_dflt", stable0, exp_stable[0]);
            check4("pulse_dflt",  pulse0,  exp_pulse[0]);
            check4("stable_long", stable1, exp_stable[1]);
            check4("pulse_long",  pulse1,  exp_pulse[1]);
`ifdef EDGE_PULSE_STICKY_EN
            check4("flag_dflt", flag0, exp_flag[0]);
            check4("flag_long", flag1, exp_flag[1]);
`endif
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int k);
        repeat (k) step();
    endtask

    typedef struct {
        logic [W-1:0] lvl;
        logic [1:0]   md;
        logic [W-1:0] exp_st;
        logic [W-1:0] exp_mask;
        int           exp_cnt;
    } vec_t;

    vec_t tbl [13];

    initial begin : main
        logic [W-1:0] mask;
        int cnt, run, best, seen;
        bit saw_hi;

        tbl[0]  = '{4'b0001, 2'b00, 4'b0001, 4'b0001, 1};
        tbl[1]  = '{4'b0000, 2'b00, 4'b0000, 4'b0000, 0};
        tbl[2]  = '{4'b0001, 2'b01, 4'b0001, 4'b0000, 0};
        tbl[3]  = '{4'b0000, 2'b01, 4'b0000, 4'b0001, 1};
        tbl[4]  = '{4'b0001, 2'b10, 4'b0001, 4'b0001, 1};
        tbl[5]  = '{4'b0000, 2'b10, 4'b0000, 4'b0001, 1};
        tbl[6]  = '{4'b1111, 2'b11, 4'b1111, 4'b0000, 0};
        tbl[7]  = '{4'b0000, 2'b11, 4'b0000, 4'b0000, 0};
        tbl[8]  = '{4'b0110, 2'b10, 4'b0110, 4'b0110, 2};
        tbl[9]  = '{4'b1010, 2'b00, 4'b1010, 4'b1000, 1};
        tbl[10] = '{4'b0101, 2'b10, 4'b0101, 4'b1111, 4};
        tbl[11] = '{4'b0000, 2'b01, 4'b0000, 4'b0101, 2};
        tbl[12] = '{4'b0000, 2'b00, 4'b0000, 4'b0000, 0};

        // Reset with all inputs high; release in rise mode.
        level = 4'hF;
        mode  = 2'b00;
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        step();
        check4("rst_stable", stable0, 4'h0);
        check4("rst_pulse",  pulse0,  4'h0);
        step();
        rst = 1'b0;
        step();
        check4("first_cycle_stable", stable0, 4'h0);
        check4("first_cycle_pulse",  pulse0,  4'h0);
        steps(4);
        check4("pre_latency_stable", stable0, 4'h0);
        step();
        check4("latency_stable", stable0, 4'hF);
        check4("latency_pulse",  pulse0,  4'hF);
        step();
        check4("pulse_one_cycle", pulse0, 4'h0);
        level = 4'h0;
        steps(12);

        // Table of level/mode steps on the default instance.
        for (int v = 0; v < 13; v++) begin
            level = tbl[v].lvl;
            mode  = tbl[v].md;
            mask  = '0;
            cnt   = 0;
            repeat (10) begin
                step();
                mask |= pulse0;
                cnt  += $countones(pulse0);
            end
            check4($sformatf("tbl%0d_stable", v), stable0, tbl[v].exp_st);
            check4($sformatf("tbl%0d_mask", v), mask, tbl[v].exp_mask);
            check_int($sformatf("tbl%0d_count", v), cnt, tbl[v].exp_cnt);
        end

        // Glitch of 3 cycles is rejected, 4 cycles is accepted.
        mode = 2'b00;
        saw_hi = 1'b0;
        cnt = 0;
        level = 4'b0010;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) level = 4'b0000;
            step();
            saw_hi |= stable0[1];
            cnt += pulse0[1];
        end
        check_int("glitch3_stable", int'(saw_hi), 0);
        check_int("glitch3_pulse", cnt, 0);
        saw_hi = 1'b0;
        cnt = 0;
        level = 4'b0010;
        for (int k = 0; k < 16; k++) begin
            if (k == 4) level = 4'b0000;
            step();
            saw_hi |= stable0[1];
            cnt += pulse0[1];
        end
        check_int("glitch4_stable", int'(saw_hi), 1);
        check_int("glitch4_pulse", cnt, 1);

        // Retrigger on the long-pulse instance: edges two cycles apart.
        mode = 2'b10;
        cnt = 0; run = 0; best = 0;
        level = 4'b0100;
        for (int k = 0; k < 17; k++) begin
            if (k == 2) level = 4'b0000;
            step();
            cnt += pulse1[2];
            run = pulse1[2] ? run + 1 : 0;
            if (run > best) best = run;
        end
        check_int("retrigger_total", cnt, 6);
        check_int("retrigger_run", best, 6);

        // Mode switched to off one cycle into a pulse: pulse completes.
        mode = 2'b00;
        level = 4'b0001;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            step();
            if (pulse1[0]) seen = 1;
        end
        check_int("midpulse_seen", seen, 1);
        mode = 2'b11;
        cnt = 1;
        repeat (8) begin
            step();
            cnt += pulse1[0];
        end
        check_int("midpulse_len", cnt, 4);
        level = 4'b0000;
        cnt = 0;
        repeat (12) begin
            step();
            cnt += $countones(pulse0) + $countones(pulse1);
        end
        check_int("off_no_pulse", cnt, 0);
        check4("off_tracks", stable0 | stable1, 4'h0);

`ifdef EDGE_PULSE_STICKY_EN
        // Sticky flag: set on event, held, cleared; set wins over clear.
        mode = 2'b00;
        flag_clr = 4'hF;
        step();
        flag_clr = 4'h0;
        check4("flag_cleared", flag0, 4'h0);
        level = 4'b1000;
        steps(10);
        check_int("flag_set", int'(flag0[3]), 1);
        steps(5);
        check_int("flag_hold", int'(flag0[3]), 1);
        flag_clr = 4'b1000;
        step();
        flag_clr = 4'h0;
        check_int("flag_clr", int'(flag0[3]), 0);
        flag_clr = 4'b1000;
        mode = 2'b10;
        level = 4'b0000;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (pulse0[3]) begin
                seen = 1;
                check_int("flag_set_wins", int'(flag0[3]), 1);
            end
        end
        check_int("flag_event_seen", seen, 1);
        check_int("flag_clr_after", int'(flag0[3]), 0);
        flag_clr = 4'h0;
`endif

        // Asynchronous reset in the middle of a pulse clears at once.
        mode = 2'b10;
        level = 4'b0000;
        steps(12);
        level = 4'b0001;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            step();
            if (pulse1[0]) seen = 1;
        end
        check_int("rstmid_seen", seen, 1);
        rst = 1'b1;
        #1;
        check4("rstmid_pulse", pulse1 | pulse0, 4'h0);
        check4("rstmid_stable", stable1 | stable0, 4'h0);
        steps(2);
        rst = 1'b0;
        steps(12);

        // Randomised stimulus against the model.
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
            level = level ^ W'($urandom & $urandom);
`ifdef EDGE_PULSE_STICKY_EN
            flag_clr = W'($urandom & $urandom & $urandom);
`endif
            if (it == 300) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            steps($urandom_range(1, 7));
        end
        steps(12);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/edge_pulse_gen.md
Name: edge_pulse_gen

Overview:
- Parametrised multi-channel level-to-pulse converter for asynchronous inputs such as buttons, switches and the TX-start request.
- Per channel, in order: a synchroniser chain, a debounce filter and a mode-selectable edge detector (rise / fall / both / off).
- Each detected edge produces a retriggerable output pulse of PULSE_LEN cycles.
- Sits between board-level inputs and the UART transmitter control logic; supersedes the single-bit rising-edge pulser.

Parameters:
- WIDTH, 4: number of independent channels.
- SYNC_STAGES, 2: flip-flops in each input synchroniser; minimum 2.
- DEBOUNCE_CYCLES, 4: consecutive mismatching cycles required before the filtered level changes; minimum 1.
- PULSE_LEN, 1: output pulse length in clk cycles; minimum 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- level  input  WIDTH  raw asynchronous input levels.
- mode  input  2  global edge mode: 00 rise, 01 fall, 10 both, 11 off.
- pulse  output  WIDTH  per-channel pulse, high for PULSE_LEN cycles per accepted edge.
- stable  output  WIDTH  per-channel debounced level.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (ports clk, rst).
- rst clears every register: synchroniser flops, debounce counters, stable, pulse counters and pulse. All outputs are 0 during reset and on the first cycle after release.
- Synchroniser: level[i] is shifted through SYNC_STAGES flops; sync_out[i] is the last flop.
- Debounce (per channel):
  - Counter cnt is sized clog2(DEBOUNCE_CYCLES)+1 bits.
  - If sync_out == stable: cnt <= 0.
  - If sync_out != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - If sync_out != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync_out and cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at sync_out never changes stable.
- Edge event: the combinational "stable about to change" condition, qualified by mode:
  - rise: 0->1 only.
  - fall: 1->0 only.
  - both: either direction.
  - off: never.
  - mode is sampled on the same edge as the event.
- Pulse counter (per channel):
  - On an event: pcnt <= PULSE_LEN (retrigger; reloads even while a pulse is active).
  - Otherwise, if pcnt != 0: pcnt <= pcnt-1.
  - pulse is registered and equals (pcnt != 0).
- Latency: a level change first sampled at edge k updates stable, and raises pulse, at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults that is edge k+5.
- Mode change while a pulse is active: the active pulse completes unchanged; the new mode applies only to later events.
- Input already high at reset release: stable rises after the debounce delay. In rise or both mode this produces one pulse; this is intended.
- Channels are fully independent, and simultaneous events on several channels are all served.
- rst asserted mid-pulse or mid-debounce: immediate clear. No pulse is produced after release for the aborted event unless the input qualifies again.

Optional Feature:
- Macro: EDGE_PULSE_STICKY_EN.
- Defined:
  - Adds input flag_clr[WIDTH] and output flag[WIDTH].
  - flag[i] is set on any accepted event on channel i and held until flag_clr[i] is sampled high.
  - Set and clear in the same cycle: set wins.
  - flag resets to 0.
- Undefined: neither port exists and no flag logic is built.

Decomposition:
- Package edge_pulse_pkg holds:
  - typedef enum logic [1:0] edge_mode_e {EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF}.
  - Helper constant functions for counter widths.
- Sub-module edge_pulse_chan: one channel (synchroniser + debounce + edge detect + pulse counter, plus the sticky flag when enabled). Instantiated WIDTH times in a generate loop by edge_pulse_gen.

Test Plan:
- Reset/idle: rst high with level=4'hF, then release with mode=00 -> pulse=0 and stable=0 through reset. 5 cycles after release, stable=4'hF and pulse=4'hF for 1 cycle.
- Rise vs fall: mode=00, level[0] 0->1 and later 1->0 (each held 10 cycles) -> exactly one pulse, on the rise, 5 edges after sampling. Repeat with mode=01 -> pulse only on the fall. Repeat with mode=10 -> two pulses.
- Glitch rejection: level[1] high for 3 cycles then low -> stable[1] and pulse[1] stay 0. Held high for 4 cycles -> stable[1]=1 and one pulse.
- Stretch/retrigger: PULSE_LEN=4, mode=10, two accepted edges on level[2] 2 cycles apart -> pulse[2] high for 6 continuous cycles.
- Mode off / mid-pulse change: mode=11 with toggles -> no pulses while stable still tracks. With PULSE_LEN=4, switching from 00 to 11 one cycle into a pulse -> the pulse still lasts 4 cycles.
- Sticky (EDGE_PULSE_STICKY_EN defined): event on ch3 -> flag[3]=1 until flag_clr[3]. Event coinciding with flag_clr[3] -> flag[3] stays 1.
